// File: rtl/ov5640_init_sequencer_pkg.sv
// Shared types and constants for the OV5640 register-table init sequencer.
package ov5640_init_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWRUP,
    S_FETCH,
    S_DECODE,
    S_WR,
    S_RD,
    S_RESP,
    S_DELAY,
    S_DONE,
    S_ERROR
  } seq_state_t;

  // One table entry as stored in the ROM: register address then value.
  typedef struct packed {
    logic [15:0] sub_addr;
    logic [7:0]  data;
  } rom_entry_t;

  localparam logic [15:0] END_MARK   = 16'hFFFE;
  localparam logic [15:0] DELAY_MARK = 16'hFFFF;
  localparam int          CNT_WIDTH  = 32;

  // Down-counter preload for a delay entry. The counter runs from the
  // preload down to zero inclusive, so the preload is one less than the
  // wanted cycle count; a zero tick count still costs one cycle.
  function automatic logic [CNT_WIDTH-1:0] delay_load(input logic [7:0] ticks,
                                                      input logic [CNT_WIDTH-1:0] unit);
    logic [CNT_WIDTH-1:0] total;
    total = CNT_WIDTH'(ticks) * unit;
    return (total == '0) ? '0 : total - 1'b1;
  endfunction

endpackage

// File: rtl/ov5640_init_sequencer_init_delay_counter.sv
// Loadable down-counter shared by the power-up wait and table delay entries.
module init_delay_counter
  import ov5640_init_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks a ROM table of {sub_addr, data} entries and issues SCCB writes,
// optional read-back verification, and timed delays to bring up an OV5640.
//
// state   | meaning
// IDLE    | waiting for start after reset
// PWRUP   | power-up settle wait before the first access
// FETCH   | rom_addr presented, ROM read latency cycle
// DECODE  | entry registered, branch on end/delay/write
// WR      | write request held until request_ready
// RD      | read-back request held until request_ready
// RESP    | waiting for the read-back byte
// DELAY   | delay-entry countdown
// DONE    | table finished cleanly
// ERROR   | read-back mismatch, err_index holds the entry
module ov5640_init_sequencer
  import ov5640_init_sequencer_pkg::*;
#(
  parameter logic [7:0] DEVICE_ADDR    = 8'h78,
  parameter int         SUB_ADDR_WIDTH = 16,
  parameter int         ROM_ADDR_WIDTH = 9,
  parameter int         POWERUP_CYCLES = 1_000_000,
  parameter int         DELAY_UNIT     = 50_000,
  parameter bit         VERIFY         = 1'b0
) (
  input  logic                      clk,
  input  logic                      rest,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [ROM_ADDR_WIDTH-1:0] err_index,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]               rom_data,
  output logic [7:0]                device_addr,
  output logic [SUB_ADDR_WIDTH-1:0] sub_addr,
  output logic                      read,
  output logic                      write,
  output logic [7:0]                write_data,
  input  logic                      request_ready,
  input  logic [7:0]                read_data,
  input  logic                      resp_valid,
  output logic                      resp_ready
);

  localparam logic [CNT_WIDTH-1:0] PWRUP_LOAD =
    (POWERUP_CYCLES > 0) ? CNT_WIDTH'(POWERUP_CYCLES - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] UNIT = CNT_WIDTH'(DELAY_UNIT);

  seq_state_t                state_q, state_d;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_ADDR_WIDTH-1:0] err_index_q, err_index_d;
  logic [SUB_ADDR_WIDTH-1:0] sub_addr_q, sub_addr_d;
  logic [7:0]                write_data_q, write_data_d;
  logic [7:0]                device_addr_q;
  logic                      read_q, read_d;
  logic                      write_q, write_d;
  logic                      resp_ready_q, resp_ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;

  rom_entry_t                entry;
  logic                      advance;
  logic                      cnt_load;
  logic [CNT_WIDTH-1:0]      cnt_load_val;
  logic                      cnt_dec;
  logic                      cnt_zero;

  init_delay_counter u_delay (
    .clk      (clk),
    .rest     (rest),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign entry   = rom_entry_t'(rom_data);
  assign cnt_dec = (state_q == S_PWRUP) || (state_q == S_DELAY);

  // Next-state, table walk and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    err_index_d  = err_index_q;
    sub_addr_d   = sub_addr_q;
    write_data_d = write_data_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    advance      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          rom_addr_d   = '0;
          err_index_d  = '0;
          cnt_load     = 1'b1;
          cnt_load_val = PWRUP_LOAD;
          state_d      = S_PWRUP;
        end
      end
      S_PWRUP:  if (cnt_zero) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (entry.sub_addr == END_MARK) begin
          state_d = S_DONE;
        end else if (entry.sub_addr == DELAY_MARK) begin
          cnt_load     = 1'b1;
          cnt_load_val = delay_load(entry.data, UNIT);
          state_d      = S_DELAY;
        end else begin
          sub_addr_d   = SUB_ADDR_WIDTH'(entry.sub_addr);
          write_data_d = entry.data;
          state_d      = S_WR;
        end
      end
      S_WR: begin
        if (request_ready) begin
          if (VERIFY) state_d = S_RD;
          else        advance = 1'b1;
        end
      end
      S_RD:     if (request_ready) state_d = S_RESP;
      S_RESP: begin
        if (resp_valid) begin
          if (read_data == write_data_q) begin
            advance = 1'b1;
          end else begin
            err_index_d = rom_addr_q;
            state_d     = S_ERROR;
          end
        end
      end
      S_DELAY:  if (cnt_zero) advance = 1'b1;
      default:  state_d = S_IDLE;
    endcase

    // The table index never wraps: the last slot ends the sequence.
    if (advance) begin
      if (rom_addr_q == {ROM_ADDR_WIDTH{1'b1}}) begin
        state_d = S_DONE;
      end else begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = S_FETCH;
      end
    end

    write_d      = (state_d == S_WR);
    read_d       = (state_d == S_RD);
    resp_ready_d = (state_d == S_RESP);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
    busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
  end

  // State and registered outputs; reset drops any request immediately.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= '0;
      err_index_q   <= '0;
      sub_addr_q    <= '0;
      write_data_q  <= '0;
      device_addr_q <= DEVICE_ADDR;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      resp_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      err_index_q   <= err_index_d;
      sub_addr_q    <= sub_addr_d;
      write_data_q  <= write_data_d;
      device_addr_q <= DEVICE_ADDR;
      read_q        <= read_d;
      write_q       <= write_d;
      resp_ready_q  <= resp_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_index   = err_index_q;
  assign rom_addr    = rom_addr_q;
  assign device_addr = device_addr_q;
  assign sub_addr    = sub_addr_q;
  assign read        = read_q;
  assign write       = write_q;
  assign write_data  = write_data_q;
  assign resp_ready  = resp_ready_q;

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Bench for ov5640_init_sequencer: one write-only instance (a) and one
// read-back-verify instance (b), each with its own ROM model.
module tb_ov5640_init_sequencer;

  localparam int PU = 10;
  localparam int DU = 100;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  logic rest = 1'b1;
  logic request_ready = 1'b0;

  logic        start_a = 1'b0, busy_a, done_a, error_a, read_a, write_a, resp_ready_a;
  logic [8:0]  err_index_a, rom_addr_a;
  logic [23:0] rom_data_a;
  logic [7:0]  device_addr_a, write_data_a;
  logic [15:0] sub_addr_a;
  logic [7:0]  read_data_a = 8'h00;
  logic        resp_valid_a = 1'b0;

  logic        start_b = 1'b0, busy_b, done_b, error_b, read_b, write_b, resp_ready_b;
  logic [8:0]  err_index_b, rom_addr_b;
  logic [23:0] rom_data_b;
  logic [7:0]  device_addr_b, write_data_b;
  logic [15:0] sub_addr_b;
  logic [7:0]  read_data_b = 8'h00;
  logic        resp_valid_b = 1'b0;

  logic [23:0] rom_a [512];
  logic [23:0] rom_b [512];
  wr_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_data_a = rom_a[rom_addr_a];
  assign rom_data_b = rom_b[rom_addr_b];

  ov5640_init_sequencer #(.POWERUP_CYCLES(PU), .DELAY_UNIT(DU), .VERIFY(1'b0)) u_dut_a (
    .clk(clk), .rest(rest), .start(start_a), .busy(busy_a), .done(done_a), .error(error_a),
    .err_index(err_index_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .device_addr(device_addr_a), .sub_addr(sub_addr_a), .read(read_a), .write(write_a),
    .write_data(write_data_a), .request_ready(request_ready), .read_data(read_data_a),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready_a));

  ov5640_init_sequencer #(.POWERUP_CYCLES(PU), .DELAY_UNIT(DU), .VERIFY(1'b1)) u_dut_b (
    .clk(clk), .rest(rest), .start(start_b), .busy(busy_b), .done(done_b), .error(error_b),
    .err_index(err_index_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .device_addr(device_addr_b), .sub_addr(sub_addr_b), .read(read_b), .write(write_b),
    .write_data(write_data_b), .request_ready(request_ready), .read_data(read_data_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b));

  // Stimulus helpers (no checking).
  task automatic load_basic();
    for (int i = 0; i < 512; i++) rom_a[i] = 24'hFFFE00;
    rom_a[0] = 24'h300882;
    rom_a[1] = 24'h310303;
    exp_q.delete();
    exp_q.push_back('{16'h3008, 8'h82});
    exp_q.push_back('{16'h3103, 8'h03});
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rest = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0 || error_a !== 1'b0) begin errors++; $display("FAIL rst_done_err: got %b%b want 00", done_a, error_a); end
    checks++; if (write_a !== 1'b0 || read_a !== 1'b0 || resp_ready_a !== 1'b0) begin errors++; $display("FAIL rst_req: got w%b r%b rr%b want 0", write_a, read_a, resp_ready_a); end
    checks++; if (rom_addr_a !== 9'd0 || err_index_a !== 9'd0) begin errors++; $display("FAIL rst_idx: got %0d/%0d want 0/0", rom_addr_a, err_index_a); end
    checks++; if (device_addr_a !== 8'h78) begin errors++; $display("FAIL rst_devaddr: got %h want 78", device_addr_a); end
    checks++; if (sub_addr_a !== 16'h0 || write_data_a !== 8'h0) begin errors++; $display("FAIL rst_addrdata: got %h/%h want 0/0", sub_addr_a, write_data_a); end
    @(posedge clk); #1;
    rest = 1'b0;
    @(posedge clk); #1;
  endtask

  // Three-entry table, no backpressure; stray resp_valid must be ignored.
  task automatic test_basic();
    int nwr = 0, bad = 0;
    bit fin = 0;
    wr_t e;
    load_basic();
    request_ready = 1'b1;
    resp_valid_a = 1'b1;
    pulse_start_a();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (read_a || resp_ready_a) bad++;
      if (write_a && request_ready) begin
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra_write: got %h/%h want none", sub_addr_a, write_data_a); end
        else begin
          e = exp_q.pop_front();
          if ({sub_addr_a, write_data_a} !== {e.a, e.d}) begin errors++; $display("FAIL basic_write: got %h/%h want %h/%h", sub_addr_a, write_data_a, e.a, e.d); end
        end
      end
      if (done_a) begin fin = 1; break; end
    end
    resp_valid_a = 1'b0;
    checks++; if (!fin) begin errors++; $display("FAIL basic_timeout: got no done want done"); end
    checks++; if (nwr != 2) begin errors++; $display("FAIL basic_count: got %0d want 2", nwr); end
    checks++; if (busy_a !== 1'b0 || error_a !== 1'b0) begin errors++; $display("FAIL basic_flags: got busy%b err%b want 0 0", busy_a, error_a); end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_no_read: got %0d cycles want 0", bad); end
  endtask

  // Start during the power-up wait must not restart the count.
  task automatic test_ignored_start();
    int n = 0;
    load_basic();
    request_ready = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL pwrup_busy: got %b want 1", busy_a); end
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 4) start_a = 1'b1;
      if (c == 5) start_a = 1'b0;
      if (write_a) begin n = c; break; end
    end
    // power-up cycles, then FETCH and DECODE before WR
    checks++; if (n != PU + 2) begin errors++; $display("FAIL ignored_start_latency: got %0d want %0d", n, PU + 2); end
    for (int c = 0; c < 50 && !done_a; c++) begin @(posedge clk); #1; end
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL ignored_start_done: got %b want 1", done_a); end
  endtask

  task automatic test_backpressure();
    int nwr = 0;
    bit seen = 0, fin = 0;
    wr_t e;
    load_basic();
    request_ready = 1'b0;
    pulse_start_a();
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (write_a) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_no_write: got 0 want 1"); end
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (write_a !== 1'b1 || sub_addr_a !== exp_q[0].a || write_data_a !== exp_q[0].d) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got w%b %h/%h want w1 %h/%h", i, write_a, sub_addr_a, write_data_a, exp_q[0].a, exp_q[0].d);
      end
    end
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      request_ready = 1'b1;
      if (write_a && request_ready) begin
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra_write: got %h want none", sub_addr_a); end
        else begin
          e = exp_q.pop_front();
          if ({sub_addr_a, write_data_a} !== {e.a, e.d}) begin errors++; $display("FAIL bp_write: got %h/%h want %h/%h", sub_addr_a, write_data_a, e.a, e.d); end
        end
      end
      if (done_a) begin fin = 1; break; end
    end
    checks++; if (!fin || nwr != 2) begin errors++; $display("FAIL bp_count: got %0d done=%b want 2 done=1", nwr, fin); end
  endtask

  // Delay entry between two writes; gap includes FETCH/DECODE on both
  // sides plus the WR cycle (5 cycles) around the delay itself.
  task automatic test_delay(input logic [7:0] ticks);
    int cyc = 0, nwr = 0, dwell = 0, t0 = 0, t1 = 0, dly, gap;
    bit fin = 0;
    wr_t e;
    load_basic();
    rom_a[1] = {16'hFFFF, ticks};
    rom_a[2] = 24'h310303;
    request_ready = 1'b1;
    dly = (ticks == 8'd0) ? 1 : int'(ticks) * DU;
    pulse_start_a();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (rom_addr_a == 9'd1) dwell++;
      if (write_a && request_ready) begin
        if (nwr == 0) t0 = cyc; else t1 = cyc;
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL delay_extra_write: got %h want none", sub_addr_a); end
        else begin
          e = exp_q.pop_front();
          if ({sub_addr_a, write_data_a} !== {e.a, e.d}) begin errors++; $display("FAIL delay_write: got %h/%h want %h/%h", sub_addr_a, write_data_a, e.a, e.d); end
        end
      end
      if (done_a) begin fin = 1; break; end
    end
    gap = t1 - t0;
    checks++; if (!fin || nwr != 2) begin errors++; $display("FAIL delay_count: got %0d done=%b want 2 done=1", nwr, fin); end
    checks++; if (dwell < dly - 2 || dwell > dly + 2) begin errors++; $display("FAIL delay_dwell: got %0d want %0d+-2", dwell, dly); end
    checks++; if (gap < dly + 3 || gap > dly + 7) begin errors++; $display("FAIL delay_gap: got %0d want %0d+-2", gap, dly + 5); end
  endtask

  task automatic test_verify_mismatch();
    int nwr = 0, nrd = 0, bad = 0, quiet = 0;
    bit fin = 0;
    logic [23:0] ent;
    wr_t e;
    for (int i = 0; i < 512; i++) rom_b[i] = 24'hFFFE00;
    rom_b[0] = 24'h300882;
    rom_b[1] = 24'h310303;
    exp_q.delete();
    exp_q.push_back('{16'h3008, 8'h82});
    exp_q.push_back('{16'h3103, 8'h03});
    request_ready = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      ent = rom_b[rom_addr_b];
      resp_valid_b = resp_ready_b;
      read_data_b = (rom_addr_b == 9'd1) ? 8'h00 : ent[7:0];
      if (read_b && write_b) bad++;
      if (read_b && request_ready) begin
        nrd++;
        checks++;
        if (device_addr_b !== 8'h78) begin errors++; $display("FAIL verify_rd_dev: got %h want 78", device_addr_b); end
      end
      if (write_b && request_ready) begin
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL verify_extra_write: got %h want none", sub_addr_b); end
        else begin
          e = exp_q.pop_front();
          if ({sub_addr_b, write_data_b} !== {e.a, e.d}) begin errors++; $display("FAIL verify_write: got %h/%h want %h/%h", sub_addr_b, write_data_b, e.a, e.d); end
        end
      end
      if (error_b) begin fin = 1; break; end
    end
    resp_valid_b = 1'b0;
    checks++; if (!fin) begin errors++; $display("FAIL verify_timeout: got no error want error"); end
    checks++; if (nwr != 2 || nrd != 2) begin errors++; $display("FAIL verify_counts: got wr%0d rd%0d want wr2 rd2", nwr, nrd); end
    checks++; if (err_index_b !== 9'd1) begin errors++; $display("FAIL verify_err_index: got %0d want 1", err_index_b); end
    checks++; if (done_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL verify_flags: got done%b busy%b want 0 0", done_b, busy_b); end
    checks++; if (bad != 0) begin errors++; $display("FAIL verify_rw_overlap: got %0d want 0", bad); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (read_b || write_b || resp_ready_b || !error_b) quiet++;
    end
    checks++; if (quiet != 0) begin errors++; $display("FAIL verify_quiet: got %0d active cycles want 0", quiet); end
  endtask

  task automatic test_midrun_reset();
    int nwr = 0, stray = 0;
    bit seen = 0, fin = 0;
    wr_t e;
    load_basic();
    request_ready = 1'b0;
    pulse_start_a();
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (write_a) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mrst_no_write: got 0 want 1"); end
    #2;
    rest = 1'b1;
    #1;
    checks++; if (write_a !== 1'b0) begin errors++; $display("FAIL mrst_write_drop: got %b want 0", write_a); end
    checks++; if (busy_a !== 1'b0 || rom_addr_a !== 9'd0) begin errors++; $display("FAIL mrst_idle: got busy%b idx%0d want 0 0", busy_a, rom_addr_a); end
    @(posedge clk); #1;
    rest = 1'b0;
    request_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (write_a || busy_a) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mrst_no_resume: got %0d active cycles want 0", stray); end
    pulse_start_a();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (write_a && request_ready) begin
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL mrst_extra_write: got %h want none", sub_addr_a); end
        else begin
          e = exp_q.pop_front();
          if ({sub_addr_a, write_data_a} !== {e.a, e.d}) begin errors++; $display("FAIL mrst_write: got %h/%h want %h/%h", sub_addr_a, write_data_a, e.a, e.d); end
        end
      end
      if (done_a) begin fin = 1; break; end
    end
    checks++; if (!fin || nwr != 2) begin errors++; $display("FAIL mrst_rerun: got %0d done=%b want 2 done=1", nwr, fin); end
  endtask

  // Full table with no end marker: must stop at the last index, no wrap.
  task automatic test_rom_wrap();
    int nwr = 0;
    bit fin = 0;
    wr_t e;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      rom_a[i] = {16'(16'h1000 + i), 8'(i)};
      exp_q.push_back('{16'(16'h1000 + i), 8'(i)});
    end
    request_ready = 1'b1;
    pulse_start_a();
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (write_a && request_ready) begin
        nwr++;
        if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL wrap_extra_write: got %h want none", sub_addr_a); end
        else begin
          e = exp_q.pop_front();
          if ({sub_addr_a, write_data_a} !== {e.a, e.d}) begin checks++; errors++; $display("FAIL wrap_write: got %h/%h want %h/%h", sub_addr_a, write_data_a, e.a, e.d); end
        end
      end
      if (done_a) begin fin = 1; break; end
    end
    checks++; if (!fin || nwr != 512) begin errors++; $display("FAIL wrap_count: got %0d done=%b want 512 done=1", nwr, fin); end
    checks++; if (rom_addr_a !== 9'd511) begin errors++; $display("FAIL wrap_index: got %0d want 511", rom_addr_a); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_leftover: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      rom_a[i] = 24'hFFFE00;
      rom_b[i] = 24'hFFFE00;
    end
    test_reset();
    test_basic();
    test_ignored_start();
    test_backpressure();
    test_delay(8'd3);
    test_delay(8'd0);
    test_verify_mismatch();
    test_midrun_reset();
    test_rom_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
